// File: rtl/save_writer_if.sv
// Bus bundle between the save writer, the save-RAM reader and the SD sector writer.
// master = save_writer side, slave = memory / SD side.
interface save_writer_if;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        sd_wstart;
    logic [23:0] sd_wsector;
    logic        sd_wreq;
    logic [8:0]  sd_waddr;
    logic [7:0]  sd_wbyte;
    logic        sd_wdone;
    logic        sd_werr;

    modport master (
        output mem_addr, mem_rd,
        input  mem_data, mem_ack,
        output sd_wstart, sd_wsector, sd_wbyte,
        input  sd_wreq, sd_waddr, sd_wdone, sd_werr
    );

    modport slave (
        input  mem_addr, mem_rd,
        output mem_data, mem_ack,
        input  sd_wstart, sd_wsector, sd_wbyte,
        output sd_wreq, sd_waddr, sd_wdone, sd_werr
    );
endinterface

// File: rtl/save_writer.sv
// Copies cartridge save RAM to consecutive SD sectors, one 512-byte sector at a time.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no save since reset; waiting for start
// S_FILL  | issue first read of the current sector
// S_WAIT  | one read outstanding; capture byte on mem_ack, issue next read
// S_WRITE | sector buffered; SD writer pulls bytes, await sd_wdone/sd_werr
// S_DONE  | last save succeeded; waiting for start
// S_FAIL  | last save failed; waiting for start
module save_writer #(
    parameter logic [23:0] SAVE_SECTOR = 24'd32768
) (
    input  logic          wclk,
    input  logic          resetn,
    input  logic          start,
    input  logic [3:0]    ram_size,
    save_writer_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [15:0]   checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      state;
    logic [13:0] sector_idx;
    logic [13:0] sector_last;
    logic [8:0]  byte_idx;
    logic [7:0]  sect_buf [512];
    logic [23:0] fill_base;

    // Byte offset of the first byte of the current sector in save RAM.
    assign fill_base = {1'b0, sector_idx, 9'd0};

    // Sector buffer: written only while a read completes during the fill phase.
    always_ff @(posedge wclk) begin
        if (state == S_WAIT && bus.mem_ack)
            sect_buf[byte_idx] <= bus.mem_data;
    end

    // Main sequencer with registered request pulses and status outputs.
    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            sector_idx     <= '0;
            sector_last    <= '0;
            byte_idx       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            checksum       <= '0;
            bus.mem_addr   <= '0;
            bus.mem_rd     <= 1'b0;
            bus.sd_wstart  <= 1'b0;
            bus.sd_wsector <= '0;
            bus.sd_wbyte   <= '0;
        end else begin
            bus.mem_rd    <= 1'b0;
            bus.sd_wstart <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        checksum <= '0;
                        if (ram_size == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            fail  <= 1'b0;
                            busy  <= 1'b0;
                        end else if (ram_size > 4'd8) begin
                            state <= S_FAIL;
                            done  <= 1'b0;
                            fail  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_FILL;
                            done        <= 1'b0;
                            fail        <= 1'b0;
                            busy        <= 1'b1;
                            sector_idx  <= '0;
                            sector_last <= (14'd2 << ram_size) - 14'd1;
                        end
                    end
                end
                S_FILL: begin
                    byte_idx     <= '0;
                    bus.mem_addr <= fill_base;
                    bus.mem_rd   <= 1'b1;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ack) begin
                        checksum <= checksum + {8'd0, bus.mem_data};
                        if (byte_idx == 9'd511) begin
                            bus.sd_wstart  <= 1'b1;
                            bus.sd_wsector <= SAVE_SECTOR + {10'd0, sector_idx};
                            state          <= S_WRITE;
                        end else begin
                            // next read goes out the cycle after this ack
                            byte_idx     <= byte_idx + 9'd1;
                            bus.mem_addr <= bus.mem_addr + 24'd1;
                            bus.mem_rd   <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.sd_wreq)
                        bus.sd_wbyte <= sect_buf[bus.sd_waddr];
                    // an error wins even when reported together with done
                    if (bus.sd_werr) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (bus.sd_wdone) begin
                        if (sector_idx == sector_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            sector_idx <= sector_idx + 14'd1;
                            state      <= S_FILL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_save_writer.sv
// Directed bench for save_writer: memory model with 3-cycle ack, SD writer model,
// pulse counters, and immediate-assertion checks against hand-computed values.
module tb_save_writer;
    logic        wclk = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  ram_size;
    logic        busy, done, fail;
    logic [15:0] checksum;

    save_writer_if bus ();

    save_writer #(.SAVE_SECTOR(24'd32768)) dut (
        .wclk     (wclk),
        .resetn   (resetn),
        .start    (start),
        .ram_size (ram_size),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .checksum (checksum)
    );

    always #5 wclk = ~wclk;

    int          total = 0;
    int          bad = 0;
    int          n_rd;
    int          n_ws;
    logic [23:0] ws_sect [64];
    logic        sd_auto = 1'b1;
    logic [23:0] werr_sector = 24'd0;

    // Pulse counters and sector log, sampled on the falling edge.
    initial begin
        n_rd = 0;
        n_ws = 0;
        forever begin
            @(negedge wclk);
            if (bus.mem_rd === 1'b1) n_rd++;
            if (bus.sd_wstart === 1'b1) begin
                ws_sect[n_ws & 63] = bus.sd_wsector;
                n_ws++;
            end
        end
    end

    // Save RAM: RAM[i] = i[7:0], ack three cycles after each read request.
    initial begin
        int          pend_cnt;
        logic [23:0] pend_addr;
        pend_cnt     = 0;
        pend_addr    = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'd0;
        forever begin
            @(negedge wclk);
            bus.mem_ack = 1'b0;
            if (!resetn) begin
                pend_cnt = 0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        bus.mem_ack  = 1'b1;
                        bus.mem_data = pend_addr[7:0];
                    end
                end
                if (bus.mem_rd === 1'b1) begin
                    pend_cnt  = 3;
                    pend_addr = bus.mem_addr;
                end
            end
        end
    end

    // SD writer: completes each sector 6 cycles after sd_wstart; on the chosen
    // sector it reports error and done together.
    initial begin
        int          sd_cnt;
        logic [23:0] cur_sect;
        sd_cnt       = 0;
        cur_sect     = '0;
        bus.sd_wdone = 1'b0;
        bus.sd_werr  = 1'b0;
        forever begin
            @(negedge wclk);
            bus.sd_wdone = 1'b0;
            bus.sd_werr  = 1'b0;
            if (!resetn) begin
                sd_cnt = 0;
            end else begin
                if (sd_cnt > 0) begin
                    sd_cnt--;
                    if (sd_cnt == 0) begin
                        bus.sd_wdone = 1'b1;
                        if (cur_sect == werr_sector) bus.sd_werr = 1'b1;
                    end
                end
                if (bus.sd_wstart === 1'b1 && sd_auto) begin
                    sd_cnt   = 6;
                    cur_sect = bus.sd_wsector;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge wclk);
    endtask

    task automatic pulse_start();
        @(negedge wclk);
        start = 1'b1;
        @(negedge wclk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k;
        k = 0;
        while (!(done === 1'b1 || fail === 1'b1) && k < budget) begin
            @(negedge wclk);
            k++;
        end
        chk(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_fail"},   32'(fail), 32'd0);
        chk({tag, "_rd"},     32'(bus.mem_rd), 32'd0);
        chk({tag, "_wstart"}, 32'(bus.sd_wstart), 32'd0);
        chk({tag, "_csum"},   32'(checksum), 32'd0);
        chk({tag, "_addr"},   32'(bus.mem_addr), 32'd0);
        chk({tag, "_sect"},   32'(bus.sd_wsector), 32'd0);
        chk({tag, "_wbyte"},  32'(bus.sd_wbyte), 32'd0);
    endtask

    // Full ram_size=1 save: 4 sectors, 2048 reads, checksum 4 x 0xFF00 mod 2^16.
    task automatic chk_full_rs1(input string tag, input int b_rd, input int b_ws);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_csum"}, 32'(checksum), 32'h0000FC00);
        chk({tag, "_nrd"},  32'(n_rd - b_rd), 32'd2048);
        chk({tag, "_nws"},  32'(n_ws - b_ws), 32'd4);
        for (int s = 0; s < 4; s++)
            chk({tag, "_sector"}, 32'(ws_sect[(b_ws + s) & 63]), 32'd32768 + 32'(s));
    endtask

    initial begin
        int b_rd;
        int b_ws;
        int k;
        resetn       = 1'b0;
        start        = 1'b0;
        ram_size     = 4'd0;
        bus.sd_wreq  = 1'b0;
        bus.sd_waddr = 9'd0;

        // reset state
        tick(3);
        chk_zero_outputs("reset");
        resetn = 1'b1;
        tick(2);

        // no save RAM: done the cycle after start, no traffic
        ram_size = 4'd0;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        chk("rs0_done", 32'(done), 32'd1);
        chk("rs0_busy", 32'(busy), 32'd0);
        chk("rs0_fail", 32'(fail), 32'd0);
        tick(10);
        chk("rs0_nrd", 32'(n_rd - b_rd), 32'd0);
        chk("rs0_nws", 32'(n_ws - b_ws), 32'd0);

        // oversize RAM: fail, no traffic
        ram_size = 4'd9;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        chk("rs9_fail", 32'(fail), 32'd1);
        chk("rs9_done", 32'(done), 32'd0);
        chk("rs9_busy", 32'(busy), 32'd0);
        tick(10);
        chk("rs9_nrd", 32'(n_rd - b_rd), 32'd0);
        chk("rs9_nws", 32'(n_ws - b_ws), 32'd0);

        // normal 2 KB save
        ram_size = 4'd1;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        chk("rs1_busy_start", 32'(busy), 32'd1);
        chk("rs1_done_clr",   32'(done), 32'd0);
        chk("rs1_fail_clr",   32'(fail), 32'd0);
        wait_end("rs1_timeout", 20000);
        chk_full_rs1("rs1", b_rd, b_ws);

        // start while busy is ignored
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        tick(3000);
        pulse_start();
        tick(500);
        pulse_start();
        wait_end("restart_timeout", 20000);
        chk_full_rs1("restart", b_rd, b_ws);

        // write error on sector index 2 of a 16-sector save (error+done together)
        ram_size    = 4'd3;
        werr_sector = 24'd32770;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        wait_end("werr_timeout", 20000);
        chk("werr_fail", 32'(fail), 32'd1);
        chk("werr_done", 32'(done), 32'd0);
        chk("werr_busy", 32'(busy), 32'd0);
        chk("werr_csum", 32'(checksum), 32'h0000FD00);
        chk("werr_nws",  32'(n_ws - b_ws), 32'd3);
        chk("werr_nrd",  32'(n_rd - b_rd), 32'd1536);
        tick(100);
        chk("werr_nrd_after", 32'(n_rd - b_rd), 32'd1536);
        chk("werr_nws_after", 32'(n_ws - b_ws), 32'd3);
        werr_sector = 24'd0;

        // SD writer pulls all 512 bytes back-to-back, never completes
        sd_auto  = 1'b0;
        ram_size = 4'd1;
        b_ws = n_ws;
        pulse_start();
        k = 0;
        while (n_ws == b_ws && k < 5000) begin
            @(negedge wclk);
            k++;
        end
        chk("pull_wstart_seen", 32'(k < 5000), 32'd1);
        chk("pull_sector", 32'(ws_sect[b_ws & 63]), 32'd32768);
        for (int i = 0; i <= 512; i++) begin
            if (i > 0)
                chk("pull_wbyte", 32'(bus.sd_wbyte), 32'((i - 1) & 255));
            if (i < 512) begin
                bus.sd_wreq  = 1'b1;
                bus.sd_waddr = 9'(i);
            end else begin
                bus.sd_wreq  = 1'b0;
                bus.sd_waddr = 9'd7;
            end
            @(negedge wclk);
        end
        chk("pull_wbyte_last", 32'(bus.sd_wbyte), 32'h000000FF);
        tick(5);
        chk("pull_wbyte_hold", 32'(bus.sd_wbyte), 32'h000000FF);
        tick(100);
        chk("pull_busy", 32'(busy), 32'd1);
        chk("pull_done", 32'(done), 32'd0);
        chk("pull_fail", 32'(fail), 32'd0);

        // leave the stalled write via reset
        resetn = 1'b0;
        tick(2);
        resetn  = 1'b1;
        sd_auto = 1'b1;
        tick(2);

        // reset in the middle of filling sector 1
        ram_size = 4'd2;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        k = 0;
        while (!(n_ws - b_ws == 1 && n_rd - b_rd >= 700) && k < 10000) begin
            @(negedge wclk);
            k++;
        end
        chk("mid_reached", 32'(k < 10000), 32'd1);
        chk("mid_busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        tick(3);
        resetn = 1'b1;
        tick(10);

        // a fresh save after the interrupted one starts over at the first sector
        ram_size = 4'd1;
        b_rd = n_rd; b_ws = n_ws;
        pulse_start();
        wait_end("after_rst_timeout", 20000);
        chk_full_rs1("after_rst", b_rd, b_ws);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
